// File: rtl/or_loop_pulse_driver.sv
// ----------------------------------------------------------------------------
// or_loop_pulse_driver
//
// Stimulus/measurement controller for the OR-gate storage-loop test
// structures. One trial per start: hold the (clearable) loop in clear,
// drive a single pulse of programmable width into the loop input, then
// watch the synchronized loop output for a latch-up. Reports whether the
// loop latched and the cycle count from the first pulse cycle to detection.
//
// Ports:
//   clk            single clock, all state on rising edge
//   rst            asynchronous, active-high reset
//   start_i        begin trial (sampled only while idle)
//   pulse_width_i  pulse length in cycles, captured at start
//   timeout_i      observation window in cycles, captured at start (0 = max)
//   loop_out_i     loop output, asynchronous to clk
//   loop_in_o      registered drive to the loop input
//   loop_clr_o     registered clear to the clearable loop variant
//   busy_o         high whenever a trial is in progress
//   done_o         one-cycle strobe at trial end
//   latched_o      trial result, held until the next trial's done
//   resolve_cnt_o  cycles from first pulse cycle to detection (or window)
// ----------------------------------------------------------------------------
module or_loop_pulse_driver #(
  parameter int WIDTH_W     = 8,
  parameter int TIMEOUT_W   = 12,
  parameter int SYNC_STAGES = 2,
  parameter int CLR_CYCLES  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [WIDTH_W-1:0]   pulse_width_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  input  logic                 loop_out_i,
  output logic                 loop_in_o,
  output logic                 loop_clr_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 latched_o,
  output logic [TIMEOUT_W-1:0] resolve_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_PULSE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [TIMEOUT_W-1:0] CNT_MAX  = '1;
  localparam int                   CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0]     CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_hi;
  logic [WIDTH_W-1:0]     width_q, width_d;
  logic [WIDTH_W-1:0]     pleft_q, pleft_d;
  logic [TIMEOUT_W-1:0]   tmo_q, tmo_d;
  logic [TIMEOUT_W-1:0]   tmo_m1;
  logic [CLR_W-1:0]       clr_cnt_q, clr_cnt_d;
  logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
  logic                   det_q, det_d;
  logic [TIMEOUT_W-1:0]   det_cnt_q, det_cnt_d;
  logic                   latched_q, latched_d;
  logic [TIMEOUT_W-1:0]   res_q, res_d;
  logic                   loop_in_q, loop_clr_q, busy_q, done_q;

  assign sync_hi = sync_q[SYNC_STAGES-1];
  assign tmo_m1  = tmo_q - TIMEOUT_W'(1);

  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    pleft_d   = pleft_q;
    tmo_d     = tmo_q;
    clr_cnt_d = clr_cnt_q;
    cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + TIMEOUT_W'(1);
    det_d     = det_q;
    det_cnt_d = det_cnt_q;
    latched_d = latched_q;
    res_d     = res_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_CLEAR;
          width_d   = pulse_width_i;
          // A zero window means "as long as the counter can measure".
          tmo_d     = (timeout_i == '0) ? CNT_MAX : timeout_i;
          clr_cnt_d = '0;
          det_d     = 1'b0;
        end
      end
      S_CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          // Cycle counter starts at 0 on the first PULSE (or WAIT) cycle.
          cnt_d   = '0;
          pleft_d = width_q - WIDTH_W'(1);
          state_d = (width_q != '0) ? S_PULSE : S_WAIT;
        end else begin
          clr_cnt_d = clr_cnt_q + CLR_W'(1);
        end
      end
      S_PULSE: begin
        // Detection is armed from c=0, so a loop that never cleared is
        // reported here as latched with a count of 0.
        if (sync_hi && !det_q) begin
          det_d     = 1'b1;
          det_cnt_d = cnt_q;
        end
        if (pleft_q == '0) begin
          // The pulse always runs full length; if the window has already
          // elapsed (W >= T) or the loop latched, the trial ends here.
          state_d = (det_d || (cnt_q >= tmo_m1)) ? S_DONE : S_WAIT;
        end else begin
          pleft_d = pleft_q - WIDTH_W'(1);
        end
      end
      S_WAIT: begin
        // Detection takes priority over a timeout in the same cycle.
        if (sync_hi) begin
          det_d     = 1'b1;
          det_cnt_d = cnt_q;
          state_d   = S_DONE;
        end else if (cnt_q == tmo_m1) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Results become visible together with done_o.
    if ((state_q != S_DONE) && (state_d == S_DONE)) begin
      latched_d = det_d;
      res_d     = det_d ? det_cnt_d : tmo_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sync_q     <= '0;
      width_q    <= '0;
      pleft_q    <= '0;
      tmo_q      <= '0;
      clr_cnt_q  <= '0;
      cnt_q      <= '0;
      det_q      <= 1'b0;
      det_cnt_q  <= '0;
      latched_q  <= 1'b0;
      res_q      <= '0;
      loop_in_q  <= 1'b0;
      loop_clr_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], loop_out_i};
      width_q    <= width_d;
      pleft_q    <= pleft_d;
      tmo_q      <= tmo_d;
      clr_cnt_q  <= clr_cnt_d;
      cnt_q      <= cnt_d;
      det_q      <= det_d;
      det_cnt_q  <= det_cnt_d;
      latched_q  <= latched_d;
      res_q      <= res_d;
      // Outputs are decoded from the next state so they leave a flop.
      loop_in_q  <= (state_d == S_PULSE);
      loop_clr_q <= (state_d == S_CLEAR);
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
    end
  end

  assign loop_in_o     = loop_in_q;
  assign loop_clr_o    = loop_clr_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign latched_o     = latched_q;
  assign resolve_cnt_o = res_q;

endmodule
